// File: rtl/step_counter_pkg.sv
// Shared types and constants for the step_counter sequence generator.
package step_counter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } sc_state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage : step_counter_pkg

// File: rtl/step_counter_step_next.sv
// Combinational next-value function: modulo-MOD add/subtract of a step,
// with wrap detection and step legality check.
module step_next
  import step_counter_pkg::*;
#(
  parameter int N   = 8,
  parameter int MOD = 200
) (
  input  logic [N-1:0] cnt,
  input  logic [N-1:0] step,
  input  logic         dir,
  output logic [N-1:0] nx,
  output logic         wrap,
  output logic         step_bad
);

  // One extra bit so cnt+step and cnt+MOD never overflow before the modulus test.
  localparam logic [N:0] MOD_W = (N+1)'(MOD);

  logic [N:0] cnt_w;
  logic [N:0] step_w;
  logic [N:0] sum_w;
  logic [N:0] res_w;

  assign cnt_w  = {1'b0, cnt};
  assign step_w = {1'b0, step};

  // Wrapped next value and wrap flag for the selected direction.
  always_comb begin
    sum_w    = cnt_w + step_w;
    res_w    = cnt_w;
    wrap     = 1'b0;
    step_bad = (step_w >= MOD_W);
    case (dir)
      DIR_UP: begin
        if (sum_w >= MOD_W) begin
          res_w = sum_w - MOD_W;
          wrap  = 1'b1;
        end else begin
          res_w = sum_w;
          wrap  = 1'b0;
        end
      end
      DIR_DN: begin
        if (cnt_w >= step_w) begin
          res_w = cnt_w - step_w;
          wrap  = 1'b0;
        end else begin
          res_w = cnt_w + MOD_W - step_w;
          wrap  = 1'b1;
        end
      end
      default: begin
        res_w = cnt_w;
        wrap  = 1'b0;
      end
    endcase
    nx = res_w[N-1:0];
  end

endmodule : step_next

// File: rtl/step_counter.sv
// Modulo-MOD step counter: run-time step, up/down, load, one-shot halt,
// terminal-count pulse and sticky illegal-input flag.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int N        = 8,
  parameter int MOD      = 200,
  parameter int DEF_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] step,
  input  logic         dir,
  input  logic         oneshot,
  output logic [N-1:0] cnt,
  output logic         tc,
  output logic         done,
  output logic         err
);

  localparam logic [N:0] MOD_W = (N+1)'(MOD);

  if ((MOD < 2) || (MOD > (2**N)) || (DEF_STEP < 0) || (DEF_STEP >= MOD)) begin : g_param_check
    $error("step_counter: illegal parameter set");
  end

  sc_state_t   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [N-1:0] nx_s;
  logic         wrap_s;
  logic         step_bad_s;
  logic         load_ok_s;
  logic         cnt_ok_s;

  step_next #(
    .N   (N),
    .MOD (MOD)
  ) u_step_next (
    .cnt      (cnt_q),
    .step     (step),
    .dir      (dir),
    .nx       (nx_s),
    .wrap     (wrap_s),
    .step_bad (step_bad_s)
  );

  assign load_ok_s = ({1'b0, load_val} < MOD_W);
  assign cnt_ok_s  = ({1'b0, cnt_q} < MOD_W);

  // Next-state logic: load > step error > advance > hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_ok_s ? cnt_q : '0;
    tc_d    = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    if (load) begin
      cnt_d   = load_ok_s ? load_val : '0;
      err_d   = ~load_ok_s;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (en && step_bad_s) begin
      err_d = 1'b1;
    end else if (en) begin
      case (state_q)
        RUN: begin
          cnt_d = nx_s;
          tc_d  = wrap_s;
          if (wrap_s && oneshot) begin
            state_d = HALT;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            done_d  = 1'b0;
          end
        end
        HALT: begin
          state_d = HALT;
          done_d  = 1'b1;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end else begin
      tc_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc   = tc_q;
  assign done = done_q;
  assign err  = err_q;

endmodule : step_counter

// File: tb/tb_step_counter.sv
// Directed bench: a small N=3/MOD=5 instance and a default N=8/MOD=200 instance.
module tb_step_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: N=3, MOD=5
  logic       a_reset, a_en, a_load, a_dir, a_oneshot;
  logic [2:0] a_load_val, a_step, a_cnt;
  logic       a_tc, a_done, a_err;

  // Instance B: N=8, MOD=200
  logic       b_reset, b_en, b_load, b_dir, b_oneshot;
  logic [7:0] b_load_val, b_step, b_cnt;
  logic       b_tc, b_done, b_err;

  step_counter #(.N(3), .MOD(5), .DEF_STEP(1)) u_a (
    .clk(clk), .reset(a_reset), .en(a_en), .load(a_load), .load_val(a_load_val),
    .step(a_step), .dir(a_dir), .oneshot(a_oneshot),
    .cnt(a_cnt), .tc(a_tc), .done(a_done), .err(a_err)
  );

  step_counter #(.N(8), .MOD(200), .DEF_STEP(1)) u_b (
    .clk(clk), .reset(b_reset), .en(b_en), .load(b_load), .load_val(b_load_val),
    .step(b_step), .dir(b_dir), .oneshot(b_oneshot),
    .cnt(b_cnt), .tc(b_tc), .done(b_done), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input int c, input int t, input int d, input int e);
    check({tag, ".cnt"},  32'(b_cnt),  32'(c));
    check({tag, ".tc"},   32'(b_tc),   32'(t));
    check({tag, ".done"}, 32'(b_done), 32'(d));
    check({tag, ".err"},  32'(b_err),  32'(e));
  endtask

  int exp_a_cnt [6] = '{3, 1, 4, 2, 0, 3};
  int exp_a_tc  [6] = '{0, 1, 0, 1, 1, 0};

  initial begin
    // ---------------- Instance A: reset with arbitrary inputs, then step 3 up
    a_reset = 1'b1; a_en = 1'b1; a_load = 1'b1; a_load_val = 3'd4;
    a_step = 3'd3; a_dir = 1'b1; a_oneshot = 1'b1;
    tick();
    check("a_rst.cnt",  32'(a_cnt),  32'd0);
    check("a_rst.tc",   32'(a_tc),   32'd0);
    check("a_rst.done", 32'(a_done), 32'd0);
    check("a_rst.err",  32'(a_err),  32'd0);

    a_reset = 1'b0; a_load = 1'b0; a_dir = 1'b0; a_oneshot = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("a_seq%0d.cnt", i), 32'(a_cnt), 32'(exp_a_cnt[i]));
      check($sformatf("a_seq%0d.tc", i),  32'(a_tc),  32'(exp_a_tc[i]));
    end
    // cnt is 3 here; reset mid-count
    a_reset = 1'b1;
    tick();
    check("a_midrst.cnt", 32'(a_cnt), 32'd0);
    check("a_midrst.tc",  32'(a_tc),  32'd0);
    a_reset = 1'b0; a_en = 1'b0;

    // ---------------- Instance B: reset
    b_reset = 1'b1; b_en = 1'b1; b_load = 1'b0; b_load_val = 8'd77;
    b_step = 8'd9; b_dir = 1'b0; b_oneshot = 1'b0;
    tick();
    check_b("b_rst", 0, 0, 0, 0);

    // Down count through zero
    b_reset = 1'b0; b_en = 1'b0; b_load = 1'b1; b_load_val = 8'd1;
    tick();
    check_b("b_ld1", 1, 0, 0, 0);
    b_load = 1'b0; b_en = 1'b1; b_step = 8'd1; b_dir = 1'b1;
    tick(); check_b("b_dn0",   0,   0, 0, 0);
    tick(); check_b("b_dn199", 199, 1, 0, 0);
    tick(); check_b("b_dn198", 198, 0, 0, 0);

    // One-shot
    b_en = 1'b0; b_load = 1'b1; b_load_val = 8'd197;
    tick(); check_b("b_os_ld", 197, 0, 0, 0);
    b_load = 1'b0; b_en = 1'b1; b_step = 8'd2; b_dir = 1'b0; b_oneshot = 1'b1;
    tick(); check_b("b_os199", 199, 0, 0, 0);
    tick(); check_b("b_os1",   1,   1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_b($sformatf("b_halt%0d", i), 1, 0, 1, 0);
    end
    b_load = 1'b1; b_load_val = 8'd5;
    tick(); check_b("b_os_ld5", 5, 0, 0, 0);
    b_load = 1'b0;
    tick(); check_b("b_os7", 7, 0, 0, 0);

    // Illegal inputs
    b_oneshot = 1'b0; b_en = 1'b0; b_load = 1'b1; b_load_val = 8'd250;
    tick(); check_b("b_badld", 0, 0, 0, 1);
    b_load = 1'b0; b_en = 1'b1; b_step = 8'd200;
    tick(); check_b("b_badstep", 0, 0, 0, 1);
    b_en = 1'b0; b_load = 1'b1; b_load_val = 8'd10;
    tick(); check_b("b_recover", 10, 0, 0, 0);

    // Load beats enable
    b_load_val = 8'd100;
    tick(); check_b("b_ld100", 100, 0, 0, 0);
    b_en = 1'b1; b_step = 8'd150; b_load_val = 8'd42;
    tick(); check_b("b_ld_en", 42, 0, 0, 0);

    // Zero step
    b_load = 1'b0; b_step = 8'd0;
    tick(); check_b("b_step0a", 42, 0, 0, 0);
    b_dir = 1'b1;
    tick(); check_b("b_step0b", 42, 0, 0, 0);

    // Step error from a clean state sets err and holds cnt
    b_step = 8'd255;
    tick(); check_b("b_step255", 42, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_step_counter
